// File: rtl/encoders_scanner_if.sv
// encoders_scanner_if: signals between the encoder mux scanner and its users.
//   master: scanner side (drives mux_addr, ready, debounced, changed, irq,
//           position; receives mux_out, flag_clear)
//   slave : board / register-block side (the mirror image)
interface encoders_scanner_if #(
  parameter int MUX_BITS = 4,
  parameter int POS_BITS = 8
);
  localparam int N = 2**MUX_BITS;

  logic [MUX_BITS-1:0]          mux_addr;
  logic                         mux_out;
  logic                         ready;
  logic [N-1:0]                 debounced;
  logic [N-1:0]                 changed;
  logic [N-1:0]                 flag_clear;
  logic                         irq;
  logic [(N/2)*POS_BITS-1:0]    position;

  modport master (
    output mux_addr, ready, debounced, changed, irq, position,
    input  mux_out, flag_clear
  );

  modport slave (
    input  mux_addr, ready, debounced, changed, irq, position,
    output mux_out, flag_clear
  );
endinterface

// File: rtl/encoders_scanner.sv
// encoders_scanner: scans N = 2^MUX_BITS multiplexed encoder inputs, debounces
// each channel with state kept in a small async-read RAM, raises sticky change
// flags with an interrupt and decodes channel pairs as quadrature into
// wrapping position counters.
//   clk, reset : clock, synchronous active-high reset
//   bus.mux_addr   : external mux select (out)
//   bus.mux_out    : selected mux output, already synchronised (in)
//   bus.ready      : low during the post-reset RAM init sweep (out)
//   bus.debounced  : debounced channel levels (out)
//   bus.changed    : sticky change flags (out)
//   bus.flag_clear : write-1-to-clear pulses for changed (in)
//   bus.irq        : registered OR of changed (out)
//   bus.position   : per-pair counters, pair k at [k*POS_BITS +: POS_BITS] (out)
module encoders_scanner #(
  parameter int MUX_BITS      = 4,
  parameter int SLOT_CYCLES   = 32,
  parameter int DEBOUNCE_BITS = 7,
  parameter logic [(2**MUX_BITS)/2-1:0] QUAD_EN = '1,
  parameter int POS_BITS      = 8
) (
  input  logic clk,
  input  logic reset,
  encoders_scanner_if.master bus
);
  localparam int N  = 2**MUX_BITS;
  localparam int P  = N/2;
  localparam int SW = $clog2(SLOT_CYCLES);
  localparam logic [SW-1:0] S_CAP  = SW'(SLOT_CYCLES-3);
  localparam logic [SW-1:0] S_UPD  = SW'(SLOT_CYCLES-2);
  localparam logic [SW-1:0] S_LAST = SW'(SLOT_CYCLES-1);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  typedef struct packed {
    logic                     out;
    logic [DEBOUNCE_BITS-1:0] cnt;
  } entry_t;

  entry_t ram [N];

  logic [0:0]                 state;
  logic [MUX_BITS-1:0]        init_addr, mux_addr;
  logic [SW-1:0]              s;
  logic                       sample, ready, irq;
  logic [N-1:0]               debounced, changed;
  logic [P-1:0][POS_BITS-1:0] pos;

  entry_t              rd, nxt, wd;
  logic                upd_slot, flip, we;
  logic [MUX_BITS-1:0] wa, a_idx, b_idx, pair;
  logic                old_a, old_b, new_a, new_b;
  logic [1:0]          ph_old, ph_new, ph_diff;
  logic [N-1:0]        set_vec;

  // Debounce update for the channel currently selected.
  always_comb begin
    rd       = ram[mux_addr];
    upd_slot = (state == ST_SCAN) && (s == S_UPD);
    flip     = 1'b0;
    nxt      = rd;
    if (sample == rd.out) begin
      nxt.cnt = '1;
    end else if (rd.cnt == '0) begin
      nxt.out = sample;
      nxt.cnt = '1;
      flip    = upd_slot;
    end else begin
      nxt.cnt = rd.cnt - 1'b1;
    end
  end

  // RAM write port: init sweep first, then one write per slot.
  always_comb begin
    we = 1'b0;
    wa = mux_addr;
    wd = nxt;
    if (!reset) begin
      if (state == ST_INIT) begin
        we     = 1'b1;
        wa     = init_addr;
        wd.out = 1'b0;
        wd.cnt = '1;
      end else if (upd_slot) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) ram[wa] <= wd;
  end

  // Quadrature: the sequence 00,01,11,10 maps to phase {A, A^B} = 0,1,2,3,
  // so the phase difference mod 4 gives direction (1 = up, 3 = down).
  always_comb begin
    a_idx   = mux_addr & ~MUX_BITS'(1);
    b_idx   = mux_addr | MUX_BITS'(1);
    pair    = mux_addr >> 1;
    old_a   = debounced[a_idx];
    old_b   = debounced[b_idx];
    new_a   = mux_addr[0] ? old_a : sample;
    new_b   = mux_addr[0] ? sample : old_b;
    ph_old  = {old_a, old_a ^ old_b};
    ph_new  = {new_a, new_a ^ new_b};
    ph_diff = ph_new - ph_old;
    set_vec = '0;
    if (flip) set_vec[mux_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      init_addr <= '0;
      mux_addr  <= '0;
      s         <= '0;
      sample    <= 1'b0;
      ready     <= 1'b0;
      debounced <= '0;
      changed   <= '0;
      irq       <= 1'b0;
      pos       <= '0;
    end else begin
      irq <= |changed;
      if (state == ST_INIT) begin
        init_addr <= init_addr + 1'b1;
        changed   <= '0;
        if (init_addr == MUX_BITS'(N-1)) begin
          state    <= ST_SCAN;
          ready    <= 1'b1;
          s        <= '0;
          mux_addr <= '0;
        end
      end else begin
        if (s == S_CAP) sample <= bus.mux_out;
        if (s == S_LAST) begin
          s        <= '0;
          mux_addr <= mux_addr + 1'b1;
        end else begin
          s <= s + 1'b1;
        end
        // A set in the same cycle as a clear wins.
        changed <= (changed & ~bus.flag_clear) | set_vec;
        if (flip) begin
          debounced[mux_addr] <= sample;
          for (int k = 0; k < P; k++) begin
            if (QUAD_EN[k] && pair == MUX_BITS'(k))
              pos[k] <= (ph_diff == 2'd1) ? pos[k] + 1'b1 : pos[k] - 1'b1;
          end
        end
      end
    end
  end

  assign bus.mux_addr  = mux_addr;
  assign bus.ready     = ready;
  assign bus.debounced = debounced;
  assign bus.changed   = changed;
  assign bus.irq       = irq;
  assign bus.position  = pos;
endmodule
